// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter
//   Shares a single-port command-driven RAM between two requesters (A, B).
//   Each accepted word transaction is expanded into the RAM's two-command
//   sequence (address-set, then data-write or read-fetch). Read data comes
//   back with a one-cycle completion pulse to the requester that issued it.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   a_valid/a_we/a_addr/a_wdata   requester A request (we: 1 = write)
//   a_ready, a_done          A accepted this cycle / A completion pulse
//   b_*                      same as A, for requester B
//   rdata, err               read data and timeout flag, valid with *_done
//   busy                     transaction in flight (state != IDLE)
//   ram_din, ram_rx_valid    RAM command word {op[1:0], byte} and strobe
//   ram_dout, ram_tx_valid   RAM read data and its valid strobe
//
// Optional build macro
//   ADDR_CACHE_EN  keep shadows of the RAM's write/read address registers
//                  and skip the address-set command when it would be a no-op.
module ram_cmd_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_done,
    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [9:0]        ram_din,
    output logic              ram_rx_valid,
    input  logic [7:0]        ram_dout,
    input  logic              ram_tx_valid
);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RCMD, RWAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              gnt_b_reg;     // latched grantee: 0 = A, 1 = B
    logic              rr_last_reg;   // last granted: 0 = A, 1 = B
    logic [7:0]        cnt_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic              grant_a, grant_b, accept, cache_hit;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the requester that was not served last wins.
    assign grant_a   = a_valid && (!b_valid || rr_last_reg);
    assign grant_b   = b_valid && (!a_valid || !rr_last_reg);
    assign accept    = (state_reg == IDLE) && (grant_a || grant_b);
    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;

`ifdef ADDR_CACHE_EN
    logic [ADDR_W-1:0] wr_sh_reg, rd_sh_reg;
    logic              wr_sh_v_reg, rd_sh_v_reg;

    // The RAM keeps its address registers between commands, so an
    // address-set to the value it already holds can be dropped.
    assign cache_hit = sel_we ? (wr_sh_v_reg && (wr_sh_reg == sel_addr))
                              : (rd_sh_v_reg && (rd_sh_reg == sel_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sh_reg   <= '0;
            rd_sh_reg   <= '0;
            wr_sh_v_reg <= 1'b0;
            rd_sh_v_reg <= 1'b0;
        end else if (state_reg == ADDR) begin
            if (we_reg) begin
                wr_sh_reg   <= addr_reg;
                wr_sh_v_reg <= 1'b1;
            end else begin
                rd_sh_reg   <= addr_reg;
                rd_sh_v_reg <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        ram_rx_valid = 1'b0;
        ram_din      = 10'h000;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        a_done       = 1'b0;
        b_done       = 1'b0;
        case (state_reg)
            IDLE: begin
                a_ready = grant_a;
                b_ready = grant_b;
                if (accept) begin
                    if (cache_hit) state_next = sel_we ? WDATA : RCMD;
                    else           state_next = ADDR;
                end
            end
            ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {(we_reg ? 2'b00 : 2'b10), addr_reg};
                state_next   = we_reg ? WDATA : RCMD;
            end
            WDATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = {2'b01, wdata_reg};
                state_next   = RESP;
            end
            RCMD: begin
                ram_rx_valid = 1'b1;
                ram_din      = {2'b11, 8'h00};
                state_next   = RWAIT;
            end
            RWAIT: begin
                if (ram_tx_valid || (cnt_reg == CNT_LAST)) state_next = RESP;
            end
            RESP: begin
                a_done     = !gnt_b_reg;
                b_done     = gnt_b_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            gnt_b_reg   <= 1'b0;
            rr_last_reg <= 1'b1;
            cnt_reg     <= 8'h00;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg      <= sel_we;
                addr_reg    <= sel_addr;
                wdata_reg   <= sel_wdata;
                gnt_b_reg   <= grant_b;
                rr_last_reg <= grant_b;
            end
            case (state_reg)
                // A write completes with clean status; set it as RESP is entered.
                WDATA: begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b0;
                end
                RCMD: cnt_reg <= 8'h00;
                RWAIT: begin
                    if (ram_tx_valid) begin
                        rdata_reg <= ram_dout;
                        err_reg   <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign err   = err_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
`timescale 1ns/1ps
module tb_ram_cmd_arbiter;

    localparam int TIMEOUT = 4;
`ifdef ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
    logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic       a_ready, a_done, b_ready, b_done, err, busy, ram_rx_valid;
    logic [7:0] rdata;
    logic [9:0] ram_din;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_tx_valid = 1'b0;

    always #5 clk = ~clk;

    ram_cmd_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_done(a_done),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_done(b_done),
        .rdata(rdata), .err(err), .busy(busy),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    // Command-driven RAM: 00 set write addr, 01 write, 10 set read addr,
    // 11 fetch (data + tx_valid registered on the command edge).
    logic [7:0] ram_mem [256];
    logic [7:0] ram_wa = 0, ram_ra = 0;
    bit         ram_mute = 0;

    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: ram_wa <= ram_din[7:0];
                2'b01: ram_mem[ram_wa] <= ram_din[7:0];
                2'b10: ram_ra <= ram_din[7:0];
                default: if (!ram_mute) begin
                    ram_tx_valid <= 1'b1;
                    ram_dout     <= ram_mem[ram_ra];
                end
            endcase
        end
    end

    // Reference model state: memory contents and the RAM's address registers.
    logic [7:0] ref_mem [256];
    bit         sh_wv = 0, sh_rv = 0;
    logic [7:0] sh_w = 0, sh_r = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0;
        ram_mute = 0;
        sh_wv = 0; sh_rv = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_txn(input bit sel, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, input bit mute);
        logic [9:0] exp_cmds[$];
        logic [9:0] got_cmds[$];
        bit         skip, seen, exp_err, got_err;
        int         exp_lat, lat, wrong;
        logic [7:0] exp_rd, got_rd;

        skip = CACHE && (we ? (sh_wv && sh_w == addr) : (sh_rv && sh_r == addr));
        if (!skip) begin
            exp_cmds.push_back({(we ? 2'b00 : 2'b10), addr});
            if (we) begin sh_w = addr; sh_wv = 1; end
            else    begin sh_r = addr; sh_rv = 1; end
        end
        exp_cmds.push_back(we ? {2'b01, wdata} : 10'h300);
        exp_lat = (skip ? 0 : 1) + (we ? 2 : (mute ? 2 + TIMEOUT : 3));
        exp_rd  = (we || mute) ? 8'h00 : ref_mem[addr];
        exp_err = !we && mute;
        if (we) ref_mem[addr] = wdata;

        @(posedge clk); #1;
        ram_mute = mute;
        if (sel) begin b_valid = 1; b_we = we; b_addr = addr; b_wdata = wdata; a_valid = 0; end
        else     begin a_valid = 1; a_we = we; a_addr = addr; a_wdata = wdata; b_valid = 0; end

        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sel ? b_ready : a_ready) begin seen = 1; break; end
        end
        check_eq("accept", 32'(seen), 32'd1);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;

        lat = 0; wrong = 0; got_rd = 0; got_err = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ram_rx_valid) got_cmds.push_back(ram_din);
            if (sel ? a_done : b_done) wrong++;
            if (sel ? b_done : a_done) begin
                lat = c; got_rd = rdata; got_err = err;
                break;
            end
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("wrong_done", 32'(wrong), 32'd0);
        check_eq("ncmd", 32'(got_cmds.size()), 32'(exp_cmds.size()));
        for (int i = 0; i < exp_cmds.size(); i++)
            if (i < got_cmds.size()) check_eq("cmd", 32'(got_cmds[i]), 32'(exp_cmds[i]));
        check_eq("rdata", 32'(got_rd), 32'(exp_rd));
        check_eq("err", 32'(got_err), 32'(exp_err));
        @(negedge clk);
        check_eq("done_pulse", 32'(a_done | b_done), 32'd0);
        check_eq("rdata_hold", 32'(rdata), 32'(exp_rd));
        $display("txn %0d: req=%s we=%0d addr=%02h wdata=%02h mute=%0d lat=%0d rdata=%02h err=%0d",
                 n_txn, sel ? "B" : "A", we, addr, wdata, mute, lat, got_rd, got_err);
        n_txn++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  found;
        logic [7:0] ad;

        // Reset values
        apply_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rx_valid", 32'(ram_rx_valid), 32'd0);
        check_eq("rst_din", 32'(ram_din), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_done", 32'(a_done | b_done), 32'd0);
        check_eq("rst_ready", 32'(a_ready | b_ready), 32'd0);

        // Both requesters held valid: grants alternate starting with A.
        @(posedge clk); #1;
        a_valid = 1; a_we = 1; a_addr = 8'h01; a_wdata = 8'h11;
        b_valid = 1; b_we = 1; b_addr = 8'h02; b_wdata = 8'h22;
        k = 0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            @(negedge clk);
            if (a_ready && b_ready) check_eq("arb_both_ready", 32'd1, 32'd0);
            else if (a_ready || b_ready) begin
                check_eq("arb_grant", 32'(b_ready), 32'(k % 2));
                $display("txn %0d: arbitration grant %0d to %s", n_txn, k, b_ready ? "B" : "A");
                n_txn++;
                k++;
            end
        end
        check_eq("arb_count", 32'(k), 32'd6);
        apply_reset();

        // Directed write / read, timeout, address-reuse sequence
        do_txn(0, 1, 8'h3C, 8'hA5, 0);
        do_txn(0, 0, 8'h3C, 8'h00, 0);
        do_txn(1, 0, 8'h10, 8'h00, 1);
        do_txn(1, 1, 8'h22, 8'hDD, 0);
        do_txn(0, 1, 8'h23, 8'hEE, 0);
        do_txn(0, 0, 8'h22, 8'h00, 0);
        do_txn(1, 0, 8'h22, 8'h00, 0);
        do_txn(0, 0, 8'h23, 8'h00, 0);

        // Reset while the read-fetch command is on the bus
        @(posedge clk); #1;
        a_valid = 1; a_we = 0; a_addr = 8'h44;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_ready) begin @(posedge clk); #1; a_valid = 0; end
            if (ram_rx_valid && ram_din == 10'h300) begin found = 1; break; end
        end
        a_valid = 0;
        check_eq("rcmd_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rx_valid", 32'(ram_rx_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(a_done | b_done), 32'd0);
        apply_reset();

        // Randomized traffic over a small address window
        for (int i = 0; i < 8; i++) do_txn(1'($urandom), 1, 8'h40 + 8'(i), 8'($urandom), 0);
        for (int i = 0; i < 30; i++) begin
            bit rw;
            rw = 1'($urandom);
            ad = 8'h40 + 8'($urandom_range(0, 7));
            do_txn(1'($urandom), rw, ad, 8'($urandom), !rw && ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Shares the single-port command-driven RAM (10-bit `din` = {op[1:0], byte}; `rx_valid`; `dout`; `tx_valid`) between two requesters, A and B.
- Accepts one word transaction at a time with round-robin arbitration.
- Expands each transaction into the RAM's two-command sequence: address-set, then data-write or read-fetch.
- Returns read data with a completion pulse. Sits between the SPI slave datapath and the RAM, in place of a direct connection.

Parameters:
- ADDR_W, 8: requester address width; must be 8 (`din[7:0]`).
- DATA_W, 8: data width; must be 8.
- TIMEOUT, 4: maximum cycles spent in RWAIT waiting for `ram_tx_valid` before an error completion; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A transaction request
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_ready  out  1  A request accepted this cycle
- a_done  out  1  A completion pulse
- b_valid, b_we, b_addr, b_wdata, b_ready, b_done: same as A, for requester B
- rdata  out  DATA_W  read data, valid with a_done/b_done
- err  out  1  read timeout flag, valid with a_done/b_done
- busy  out  1  state != IDLE
- ram_din  out  10  RAM command word
- ram_rx_valid  out  1  RAM command strobe
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read-data valid

Behaviour:
- Reset (async): state = IDLE; all outputs 0 (ram_din = 10'h000, rdata = 0); rr_last = B, so A wins the first tie; counter = 0; address shadows invalid.
- Reset mid-operation aborts the transaction immediately. No done pulse is given and ram_rx_valid drops combinationally with the state.
- States: IDLE, ADDR, WDATA, RCMD, RWAIT, RESP.
- IDLE:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one that is not rr_last.
  - x_ready = 1 combinationally for the grantee only, and only in IDLE.
  - On the accept edge: latch we/addr/wdata and the grantee id; update rr_last; go to ADDR.
- ADDR: ram_rx_valid = 1; ram_din = {we ? 2'b00 : 2'b10, addr}. Next state is WDATA if we, else RCMD.
- WDATA: ram_rx_valid = 1; ram_din = {2'b01, wdata}; next RESP.
- RCMD: ram_rx_valid = 1; ram_din = {2'b11, 8'h00}; clear counter; next RWAIT.
- RWAIT:
  - ram_rx_valid = 0.
  - If ram_tx_valid: capture ram_dout into rdata, err = 0, go to RESP.
  - Else, if counter == TIMEOUT-1: rdata = 0, err = 1, go to RESP.
  - Else increment the counter.
  - Normally exits on the first RWAIT cycle, because the RAM registers tx_valid on the RCMD edge.
- RESP: x_done = 1 for exactly one cycle for the latched grantee; rdata/err held. Next IDLE.
  - For writes: rdata = 0, err = 0.
  - rdata/err persist until the next completion.
- Latency, from the accept edge to the done cycle: write = 3 cycles (ADDR, WDATA, RESP); read = 4 cycles (ADDR, RCMD, RWAIT, RESP).
- ram_rx_valid is never high in IDLE, RWAIT or RESP.
- At most one transaction is in flight. A requester must hold valid and its fields stable until ready.
- A new request can be accepted in the cycle after RESP; there is no back-to-back overlap.
- Requests arriving while busy are ignored (ready stays 0).
- A requester may drop valid before ready; nothing happens.

Optional Feature:
- Macro: ADDR_CACHE_EN.
- Defined:
  - Keep a write-address shadow (wr_sh, wr_sh_v) and a read-address shadow (rd_sh, rd_sh_v). These mirror the RAM's internal write and read address registers.
  - Update wr_sh on every ADDR issue with op 00, and rd_sh on every ADDR issue with op 10.
  - On accept, if the matching shadow is valid and equal to addr, skip ADDR: go directly to WDATA (write) or RCMD (read).
  - Cached latency: write = 2 cycles, read = 3 cycles.
  - Both shadows are invalidated by reset.
- Undefined: ADDR is always issued and there is no shadow logic.

Test Plan:
- Reset hold, then release -> all outputs 0, busy = 0, state IDLE; asserting rst_n = 0 mid-RCMD drops ram_rx_valid in the same cycle.
- A write addr 8'h3C, data 8'hA5 -> ram_din 10'h03C then 10'h1A5 on consecutive cycles; a_done 3 cycles after accept with err = 0.
- A read addr 8'h3C, RAM model returns 8'hA5 -> ram_din 10'h23C then 10'h300; a_done 4 cycles after accept with rdata = 8'hA5, err = 0.
- A and B both valid from reset, held continuously -> grants alternate A, B, A, B; no requester is granted twice consecutively while the other waits.
- RAM model that never asserts tx_valid, read addr 8'h10 -> RWAIT lasts TIMEOUT = 4 cycles; done with rdata = 0, err = 1.
- ADDR_CACHE_EN defined, two reads to 8'h22 -> the second issues only 10'h300 and completes 3 cycles after accept; a read to 8'h23 issues ADDR again.
